// File: rtl/mips_bus_lsu.sv
// Avalon-MM master load/store unit for the multicycle MIPS core: byte-lane
// steering, waitrequest handling with optional timeout, and load extension.
module mips_bus_lsu #(
  parameter int          DATA_W     = 32,
  parameter bit          BIG_ENDIAN = 1'b0,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [31:0]         address,
  output logic                read,
  output logic                write,
  input  logic                waitrequest,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   readdata,
  output logic                busy
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFS_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t           state_q;
  logic [OFS_W-1:0] ofs_q;
  logic [1:0]       size_q;
  logic             signed_q;
  logic             write_q;
  logic [CNT_W-1:0] cnt_q;

  // Bus lane carrying byte i (0 = least significant) of an n-byte value at offset ofs.
  function automatic int unsigned lane_of(int unsigned ofs, int unsigned n, int unsigned i);
    return BIG_ENDIAN ? (ofs + n - 1 - i) : (ofs + i);
  endfunction

  int unsigned       req_ofs;
  int unsigned       req_n;
  logic              req_ok;
  logic [BE_W-1:0]   be_d;
  logic [DATA_W-1:0] wd_d;

  always_comb begin
    req_ofs = 32'(req_addr[OFS_W-1:0]);
    req_n   = 32'd1 << req_size;
    req_ok  = (req_n <= BE_W) && ((req_ofs & (req_n - 1)) == 0);
    be_d    = '0;
    wd_d    = '0;
    for (int unsigned j = 0; j < BE_W; j++) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (i < req_n && j == lane_of(req_ofs, req_n, i)) begin
          be_d[j]        = 1'b1;
          wd_d[j*8 +: 8] = req_wdata[i*8 +: 8];
        end
      end
    end
  end

  int unsigned       ld_ofs;
  int unsigned       ld_n;
  logic [DATA_W-1:0] ld_raw;
  logic [DATA_W-1:0] ld_ext;
  logic              ld_sign;

  // Inverse lane mapping on the returned word, then extension above the loaded size.
  always_comb begin
    ld_ofs  = 32'(ofs_q);
    ld_n    = 32'd1 << size_q;
    ld_raw  = '0;
    ld_sign = 1'b0;
    for (int unsigned j = 0; j < BE_W; j++) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (i < ld_n && j == lane_of(ld_ofs, ld_n, i)) begin
          ld_raw[i*8 +: 8] = readdata[j*8 +: 8];
        end
      end
    end
    case (size_q)
      2'd0:    ld_sign = ld_raw[7];
      2'd1:    ld_sign = ld_raw[15];
      2'd2:    ld_sign = ld_raw[31];
      default: ld_sign = ld_raw[DATA_W-1];
    endcase
    ld_ext = ld_raw;
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (i >= ld_n) begin
        ld_ext[i*8 +: 8] = {8{signed_q & ld_sign}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      ofs_q      <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      write_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (!req_ok) begin
              state_q   <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state_q    <= BUS;
              address    <= {req_addr[31:OFS_W], {OFS_W{1'b0}}};
              read       <= ~req_write;
              write      <= req_write;
              byteenable <= be_d;
              writedata  <= wd_d;
              ofs_q      <= req_addr[OFS_W-1:0];
              size_q     <= req_size;
              signed_q   <= req_signed;
              write_q    <= req_write;
            end
          end
        end
        BUS: begin
          // Completion wins over timeout when waitrequest drops on the last allowed cycle.
          if (!waitrequest) begin
            state_q   <= RESP;
            read      <= 1'b0;
            write     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= write_q ? '0 : ld_ext;
          end else if (TIMEOUT > 0 && cnt_q == CNT_LAST) begin
            state_q   <= RESP;
            read      <= 1'b0;
            write     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          state_q   <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          cnt_q     <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_bus_lsu.sv
// Scoreboard bench for mips_bus_lsu: a 32-bit little-endian unit with timeout
// and a 64-bit big-endian unit without, driven by the same request stream.
module tb_mips_bus_lsu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0, readdata = '0;
  logic        waitrequest = 1'b0;

  logic        r0_ready, r0_valid, r0_err, rd0, wr0, busy0;
  logic [31:0] r0_rdata, a0, wd0;
  logic [3:0]  be0;
  logic        r1_ready, r1_valid, r1_err, rd1, wr1, busy1;
  logic [63:0] r1_rdata, wd1;
  logic [31:0] a1;
  logic [7:0]  be1;

  mips_bus_lsu #(.DATA_W(32), .BIG_ENDIAN(1'b0), .TIMEOUT(4)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(r0_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .rsp_valid(r0_valid),
    .rsp_rdata(r0_rdata), .rsp_err(r0_err), .address(a0), .read(rd0), .write(wr0),
    .waitrequest(waitrequest), .writedata(wd0), .byteenable(be0),
    .readdata(readdata[31:0]), .busy(busy0));

  mips_bus_lsu #(.DATA_W(64), .BIG_ENDIAN(1'b1), .TIMEOUT(0)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(r1_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(r1_valid),
    .rsp_rdata(r1_rdata), .rsp_err(r1_err), .address(a1), .read(rd1), .write(wr1),
    .waitrequest(waitrequest), .writedata(wd1), .byteenable(be1),
    .readdata(readdata), .busy(busy1));

  typedef struct packed { logic [31:0] cyc; logic err; logic [63:0] rdata; } rsp_t;
  typedef struct packed {
    logic [31:0] addr; logic rd; logic [7:0] be; logic [63:0] wd; logic [31:0] len;
  } bus_t;

  rsp_t rsp_q[2][$];
  bus_t bus_q[2][$];
  int   n_pass = 0, n_tot = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;
  logic prev_s[2] = '{1'b0, 1'b0};
  int   run_len[2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", nm, d, act, exp, cyc);
  endtask

  task automatic fail_evt(input string nm, input int d);
    n_tot++;
    $display("FAIL %s dut%0d: got event expected none (cycle %0d)", nm, d, cyc);
  endtask

  function automatic logic [63:0] nmask(input int n);
    return (n >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
  endfunction

  function automatic logic [63:0] bswap(input logic [63:0] v, input int n);
    logic [63:0] r = '0;
    for (int k = 0; k < n; k++) r[8*(n-1-k) +: 8] = v[8*k +: 8];
    return r;
  endfunction

  // Reference: lanes are value bytes (byte-reversed for big endian) shifted up by the offset.
  task automatic expect_txn(input int d, input int dw, input bit bigend, input int to,
                            input logic wr, input logic [1:0] sz, input logic sg,
                            input logic [31:0] ad, input logic [63:0] wdat,
                            input logic [63:0] rdat, input int w, input int c, input int cut);
    int bw, n, o;
    logic [63:0] v, dmask;
    bus_t bx;
    rsp_t rx;
    bw = dw / 8;
    n = 1 << sz;
    o = int'(ad[2:0]) % bw;
    dmask = nmask(bw);
    if (n > bw || (o % n) != 0) begin
      rx.cyc = 32'(c + 1); rx.err = 1'b1; rx.rdata = '0;
      rsp_q[d].push_back(rx);
      return;
    end
    bx.addr = ad & ~32'(bw - 1);
    bx.rd = ~wr;
    bx.be = 8'(((1 << n) - 1) << o);
    v = wdat & nmask(n);
    if (bigend) v = bswap(v, n);
    bx.wd = (v << (8 * o)) & dmask;
    v = (rdat >> (8 * o)) & nmask(n);
    if (bigend) v = bswap(v, n);
    if (sg && v[8*n-1]) v = v | ~nmask(n);
    v = v & dmask;
    if (cut > 0) begin
      bx.len = 32'(cut);
    end else if (to > 0 && w >= to) begin
      bx.len = 32'(to);
      rx.cyc = 32'(c + 1 + to); rx.err = 1'b1; rx.rdata = '0;
      rsp_q[d].push_back(rx);
    end else begin
      bx.len = 32'(w + 1);
      rx.cyc = 32'(c + 2 + w); rx.err = 1'b0; rx.rdata = wr ? 64'd0 : v;
      rsp_q[d].push_back(rx);
    end
    bus_q[d].push_back(bx);
  endtask

  task automatic mon(input int d, input logic v, input logic e, input logic [63:0] rdt,
                     input logic r, input logic w, input logic [31:0] ad,
                     input logic [7:0] b, input logic [63:0] wdv);
    bus_t bx;
    rsp_t rx;
    if (r || w) begin
      chk("rw_exclusive", d, 64'(r & w), 64'd0);
      if (bus_q[d].size() == 0) fail_evt("bus_strobe", d);
      else begin
        bx = bus_q[d][0];
        chk("address", d, 64'(ad), 64'(bx.addr));
        chk("read_vs_write", d, 64'(r), 64'(bx.rd));
        chk("byteenable", d, 64'(b), 64'(bx.be));
        if (w) chk("writedata", d, wdv, bx.wd);
        run_len[d]++;
      end
    end else if (prev_s[d]) begin
      if (bus_q[d].size() != 0) begin
        bx = bus_q[d].pop_front();
        chk("strobe_cycles", d, 64'(run_len[d]), 64'(bx.len));
      end
      run_len[d] = 0;
    end
    prev_s[d] = r | w;
    if (v) begin
      if (rsp_q[d].size() == 0) fail_evt("rsp_valid", d);
      else begin
        rx = rsp_q[d].pop_front();
        chk("rsp_cycle", d, 64'(cyc), 64'(rx.cyc));
        chk("rsp_err", d, 64'(e), 64'(rx.err));
        chk("rsp_rdata", d, rdt, rx.rdata);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, r0_valid, r0_err, 64'(r0_rdata), rd0, wr0, a0, 8'(be0), 64'(wd0));
      mon(1, r1_valid, r1_err, r1_rdata, rd1, wr1, a1, be1, wd1);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!(r0_ready && r1_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_evt("ready_timeout", 2);
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] ad,
                       input logic [63:0] wdat, input logic [63:0] rdat, input int w);
    int c;
    wait_ready();
    c = cyc;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wdat;
    expect_txn(0, 32, 1'b0, 4, wr, sz, sg, ad, wdat, rdat, w, c, 0);
    expect_txn(1, 64, 1'b1, 0, wr, sz, sg, ad, wdat, rdat, w, c, 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    waitrequest = (w > 0);
    readdata = (w > 0) ? ~rdat : rdat;
    for (int k = 1; k <= w; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == w) begin
        waitrequest = 1'b0;
        readdata = rdat;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    repeat (3) @(negedge clk);
    chk("reset_ready", 0, 64'(r0_ready), 64'd1);
    chk("reset_ready", 1, 64'(r1_ready), 64'd1);
    chk("reset_outs", 0, 64'({r0_valid, r0_err, rd0, wr0, busy0}), 64'd0);
    chk("reset_outs", 1, 64'({r1_valid, r1_err, rd1, wr1, busy1}), 64'd0);
    chk("reset_bus", 0, 64'({a0, be0}) | 64'(wd0) | 64'(r0_rdata), 64'd0);
    chk("reset_bus", 1, 64'({a1, be1}) | wd1 | r1_rdata, 64'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    issue(1'b1, 2'd2, 1'b0, 32'h100, 64'h11223344, 64'd0, 0);
    issue(1'b0, 2'd0, 1'b1, 32'h103, 64'd0, 64'h80FFFFFF, 2);
    issue(1'b0, 2'd0, 1'b0, 32'h103, 64'd0, 64'h80FFFFFF, 2);
    issue(1'b1, 2'd1, 1'b0, 32'h202, 64'hABCD, 64'd0, 0);
    issue(1'b0, 2'd1, 1'b0, 32'h202, 64'd0, 64'hCDAB0000, 0);
    issue(1'b0, 2'd2, 1'b0, 32'h101, 64'd0, 64'h12345678, 0);
    issue(1'b0, 2'd3, 1'b0, 32'h100, 64'd0, 64'h0123456789ABCDEF, 0);
    issue(1'b0, 2'd2, 1'b1, 32'h40, 64'd0, 64'hFEDCBA98, 6);
    issue(1'b0, 2'd2, 1'b0, 32'h44, 64'd0, 64'h00000000CAFEF00D, 3);
    issue(1'b0, 2'd2, 1'b0, 32'h48, 64'd0, 64'h00000000CAFEF00D, 4);
    issue(1'b0, 2'd3, 1'b1, 32'h008, 64'd0, 64'h8877665544332211, 1);

    for (int t = 0; t < 120; t++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom, {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 6)));
    end

    // Reset while the 64-bit unit is still stalled on the bus.
    wait_ready();
    c = cyc;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h40;
    expect_txn(0, 32, 1'b0, 4, 1'b0, 2'd2, 1'b0, 32'h40, 64'd0, 64'd0, 100, c, 0);
    expect_txn(1, 64, 1'b1, 0, 1'b0, 2'd2, 1'b0, 32'h40, 64'd0, 64'd0, 100, c, 7);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    waitrequest = 1'b1;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_drops_read", 1, 64'(rd1), 64'd0);
    chk("reset_ready_back", 1, 64'(r1_ready), 64'd1);
    chk("reset_no_rsp", 1, 64'(r1_valid), 64'd0);
    chk("reset_busy", 1, 64'(busy1), 64'd0);
    reset = 1'b0;
    waitrequest = 1'b0;
    @(negedge clk);
    issue(1'b0, 2'd3, 1'b0, 32'h008, 64'd0, 64'h0011223344556677, 0);
    issue(1'b1, 2'd2, 1'b0, 32'h100, 64'h11223344, 64'd0, 1);

    repeat (20) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rsp_left", d, 64'(rsp_q[d].size()), 64'd0);
      chk("bus_left", d, 64'(bus_q[d].size()), 64'd0);
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/mips_bus_lsu.md
Name: mips_bus_lsu

Overview:
Parametrised load/store unit between the multicycle MIPS core and the Avalon memory-mapped bus (master side). It accepts one core memory request at a time and generates the bus address and byte lanes. It handles the waitrequest handshake with a timeout, then returns right-aligned, sign- or zero-extended load data. It replaces ad-hoc byte-lane and endian logic in the CPU top level, and generalises it to 32/64-bit buses, selectable endianness and error reporting.

Parameters:
DATA_W, 32, bus data width; legal values 32 or 64; BE_W = DATA_W/8, OFS_W = log2(BE_W).
BIG_ENDIAN, 0, 0 = byte at lowest address is least significant; 1 = most significant.
TIMEOUT, 0, max consecutive waitrequest-high cycles before abort; 0 = never time out.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high.
req_valid  in  1  core request present.
req_ready  out  1  unit can accept a request.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_W = 64).
req_signed  in  1  sign-extend load result.
req_addr  in  32  byte address.
req_wdata  in  DATA_W  right-aligned store data.
rsp_valid  out  1  one-cycle completion pulse.
rsp_rdata  out  DATA_W  right-aligned, extended load data (0 for stores).
rsp_err  out  1  qualifies rsp_valid: misaligned, illegal size or timeout.
address  out  32  bus address, low OFS_W bits always 0.
read  out  1  Avalon read.
write  out  1  Avalon write.
waitrequest  in  1  Avalon stall.
writedata  out  DATA_W  lane-positioned store data.
byteenable  out  BE_W  active lanes.
readdata  in  DATA_W  valid in the cycle where read = 1 and waitrequest = 0.
busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0 except req_ready = 1; state IDLE; timeout counter 0. Reset mid-transaction drops read/write on the next edge; no response is issued.
- Registered FSM with three states: IDLE, BUS, RESP.
- IDLE
  - req_ready = 1.
  - On req_valid, compute offset o = req_addr[OFS_W-1:0] and size bytes n = 1 << req_size.
  - If req_size is illegal or o mod n != 0: go to RESP with rsp_err = 1. No bus cycle.
  - Otherwise latch the request. On the same edge, drive address = {req_addr[31:OFS_W], 0}, read = ~req_write, write = req_write, byteenable and writedata. Go to BUS.
- Lanes
  - byteenable bits o .. o+n-1 set.
  - Byte i of the value (i = 0 is least significant) goes to lane o+i when BIG_ENDIAN = 0, and lane o+n-1-i when BIG_ENDIAN = 1.
  - Unused writedata lanes are 0.
- BUS
  - address, read, write, byteenable and writedata are held stable while waitrequest = 1. The counter increments each such cycle.
  - When waitrequest = 0: drop read/write on the next edge. For a load, capture the selected lanes, reassemble them with the inverse mapping and extend to DATA_W (sign if req_signed, else zero). Go to RESP, rsp_err = 0.
  - If TIMEOUT > 0 and the counter reaches TIMEOUT while waitrequest is still 1: drop read/write, rsp_rdata = 0, rsp_err = 1, go to RESP.
  - waitrequest falling in the same cycle the counter would hit TIMEOUT counts as success.
- RESP
  - rsp_valid = 1 for exactly one cycle, with rsp_rdata/rsp_err stable. req_ready = 0.
  - Next state IDLE. Counter cleared.
- Latency: request accepted at edge 0 -> bus strobe visible cycle 1. With zero wait states, rsp_valid is in cycle 2; each wait state adds 1 cycle. Errors detected in IDLE give rsp_valid in cycle 1.
- read and write are never both 1. Exactly one response per accepted request. Requests in non-IDLE states are ignored (req_ready = 0).
- rsp_rdata holds its last value until the next response.

Test Plan:
- DATA_W = 32, BIG_ENDIAN = 0: store word 0x11223344 to 0x100 with 0 waits -> address 0x100, byteenable 1111, writedata 0x11223344, rsp_valid at cycle 2, rsp_err = 0.
- Load byte signed from 0x103 with readdata 0x80FFFFFF, 2 wait states -> byteenable 1000, read held 3 cycles, rsp_rdata 0xFFFFFF80, rsp_valid at cycle 4. Unsigned variant -> 0x00000080.
- BIG_ENDIAN = 1: store half 0xABCD to 0x202 -> byteenable 1100, writedata 0xCDAB0000. Load back with the same readdata -> 0x0000ABCD.
- Misaligned load word at 0x101, and size 3 with DATA_W = 32 -> no read/write asserted, rsp_valid at cycle 1 with rsp_err = 1.
- TIMEOUT = 4, waitrequest stuck high -> read high 4 cycles, then dropped, rsp_err = 1, rsp_rdata = 0. Next request accepted normally.
- DATA_W = 64: load dword 0x008 -> address 0x008, byteenable 0xFF, full readdata returned. Reset asserted in BUS -> read = 0 next cycle, no rsp_valid, req_ready = 1.
